// File: rtl/hack_pkg.sv
// Shared types and constants for the multi-cycle Hack CPU: FSM states,
// instruction-register bit positions, jump codes and the jump decision.
package hack_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_MREAD  = 3'd1,
        S_EXEC   = 3'd2,
        S_MWRITE = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam int IR_CI = 15;  // 1 = C-instruction
    localparam int IR_AM = 12;  // ALU y operand: 1 = M, 0 = A
    localparam int IR_ZX = 11;  // top of the six ALU control bits
    localparam int IR_NO = 6;   // bottom of the six ALU control bits
    localparam int IR_DA = 5;
    localparam int IR_DD = 4;
    localparam int IR_DM = 3;

    localparam logic [2:0] J_NULL = 3'b000;
    localparam logic [2:0] J_GT   = 3'b001;
    localparam logic [2:0] J_EQ   = 3'b010;
    localparam logic [2:0] J_GE   = 3'b011;
    localparam logic [2:0] J_LT   = 3'b100;
    localparam logic [2:0] J_NE   = 3'b101;
    localparam logic [2:0] J_LE   = 3'b110;
    localparam logic [2:0] J_MP   = 3'b111;

    function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
        logic take;
        take = 1'b0;
        case (jmp)
            J_GT:    take = !zr && !ng;
            J_EQ:    take = zr;
            J_GE:    take = !ng;
            J_LT:    take = ng;
            J_NE:    take = !zr;
            J_LE:    take = zr || ng;
            J_MP:    take = 1'b1;
            default: take = 1'b0;
        endcase
        return take;
    endfunction

endpackage

// File: rtl/hack_alu_p.sv
// Combinational Hack ALU (zx,nx,zy,ny,f,no) with zero/negative flags.
// Zero latency; no handshake.
module hack_alu_p #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] x_i,
    input  logic [DATA_W-1:0] y_i,
    input  logic [5:0]        ctrl_i,
    output logic [DATA_W-1:0] res_o,
    output logic              zr_o,
    output logic              ng_o
);

    logic [DATA_W-1:0] xs;
    logic [DATA_W-1:0] ys;
    logic [DATA_W-1:0] r;

    always_comb begin
        xs = ctrl_i[5] ? '0 : x_i;
        if (ctrl_i[4]) xs = ~xs;
        ys = ctrl_i[3] ? '0 : y_i;
        if (ctrl_i[2]) ys = ~ys;
        r = ctrl_i[1] ? (xs + ys) : (xs & ys);
        if (ctrl_i[0]) r = ~r;
    end

    assign res_o = r;
    assign zr_o  = (r == '0);
    assign ng_o  = r[DATA_W-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: FETCH -> [MREAD] -> EXEC -> [MWRITE], 2..4 states per instruction.
// Every memory request is held with stable address/data until its ack; acks are otherwise ignored.
module hack_cpu_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hlt,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_rd_req,
    output logic              dmem_wr_req,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    import hack_pkg::*;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, daddr_q, daddr_d;
    logic [DATA_W-1:0] a_q, a_d, d_q, d_d, ir_q, ir_d, mdr_q, mdr_d, wdata_q, wdata_d;
    logic              freq_q, freq_d;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zr, alu_ng;
    logic [ADDR_W-1:0] pc_inc;

    hack_alu_p #(.DATA_W(DATA_W)) u_alu (
        .x_i    (d_q),
        .y_i    (ir_q[IR_AM] ? mdr_q : a_q),
        .ctrl_i (ir_q[IR_ZX:IR_NO]),
        .res_o  (alu_res),
        .zr_o   (alu_zr),
        .ng_o   (alu_ng)
    );

    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        a_d         = a_q;
        d_d         = d_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        daddr_d     = daddr_q;
        wdata_d     = wdata_q;
        freq_d      = freq_q;
        imem_req    = 1'b0;
        dmem_rd_req = 1'b0;
        dmem_wr_req = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // hlt only counts before the fetch request has gone out
                if (!freq_q && hlt) begin
                    state_d = S_HALT;
                end else begin
                    imem_req = reset_n;
                    freq_d   = 1'b1;
                    if (imem_ack) begin
                        ir_d   = imem_data;
                        freq_d = 1'b0;
                        if (imem_data[IR_CI] && imem_data[IR_AM]) begin
                            daddr_d = a_q[ADDR_W-1:0];
                            state_d = S_MREAD;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                end
            end
            S_MREAD: begin
                dmem_rd_req = 1'b1;
                if (dmem_ack) begin
                    mdr_d   = dmem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                if (!ir_q[IR_CI]) begin
                    a_d = DATA_W'(ir_q[IR_CI-1:0]);
                end else begin
                    if (ir_q[IR_DA]) a_d = alu_res;
                    if (ir_q[IR_DD]) d_d = alu_res;
                    // jump target and write address both use A from before this update
                    if (jump_taken(ir_q[2:0], alu_zr, alu_ng)) pc_d = a_q[ADDR_W-1:0];
                    if (ir_q[IR_DM]) begin
                        daddr_d = a_q[ADDR_W-1:0];
                        wdata_d = alu_res;
                        state_d = S_MWRITE;
                    end
                end
            end
            S_MWRITE: begin
                dmem_wr_req = 1'b1;
                if (dmem_ack) state_d = S_FETCH;
            end
            S_HALT: begin
                if (!hlt) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            daddr_q <= '0;
            wdata_q <= '0;
            freq_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            daddr_q <= daddr_d;
            wdata_q <= wdata_d;
            freq_q  <= freq_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = wdata_q;
    assign pc         = pc_q;
    assign halted     = (state_q == S_HALT);

endmodule
